// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x DATA_W register file, NUM_RD async reads, one sync write, clear sweep on reset; define RF_BYPASS_EN for write-through forwarding
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        rc,
  input  logic [DATA_W-1:0]        dc,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] da,
  output logic                     busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic we;
  assign busy = state_q == CLEAR;
  assign we = !busy && RegWrite && 32'(rc) < DEPTH && !(ZERO_REG != 0 && rc == '0);
  always_comb begin
    state_d = (busy && clr_idx_q == ADDR_W'(DEPTH - 1)) ? RUN : state_q;
    clr_idx_d = busy ? clr_idx_q + ADDR_W'(1) : clr_idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  // the reset edge itself leaves storage alone; the sweep that follows zeroes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) mem_q[clr_idx_q] <= '0;
      else if (we) mem_q[rc] <= dc;
    end
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic hit;
    assign a = ra[g*ADDR_W +: ADDR_W];
    assign hit = !busy && 32'(a) < DEPTH && !(ZERO_REG != 0 && a == '0);
`ifdef RF_BYPASS_EN
    assign da[g*DATA_W +: DATA_W] = !hit ? '0 : (we && a == rc) ? dc : mem_q[a];
`else
    assign da[g*DATA_W +: DATA_W] = hit ? mem_q[a] : '0;
`endif
  end
endmodule
